// File: rtl/mod_frame_scheduler.sv
// -----------------------------------------------------------------------------
// mod_frame_scheduler
//
// Bit-slot scheduler that feeds a serial-to-parallel modulation converter.
// Every clock cycle is one bit slot. A symbol is 2 slots (QPSK) or 4 slots
// (16QAM). The output stream is a sequence of whole symbols of three kinds:
//   PAD   - idle symbols, serial_out = 0
//   FRAME - (len+1) symbols of source bits pulled from the granted requester
//   GUARD - GUARD_SYMS symbols of zeros after every frame
// A round-robin arbiter between two requesters decides at the edge that
// starts the last slot of a PAD symbol or of the final GUARD symbol.
//
// Ports
//   clk           in   clock, rising edge
//   rst           in   asynchronous active-high reset
//   req[1:0]      in   per-requester frame request (level)
//   req_mod_type  in   per-requester modulation, 0 = QPSK, 1 = 16QAM
//   req_len0/1    in   per-requester frame length in symbols minus one
//   src_bit[1:0]  in   per-requester data bit, sampled after a src_rd slot
//   gnt[1:0]      out  one-hot grant pulse in the decision slot
//   src_rd[1:0]   out  bit-pull strobe of the granted requester
//   serial_out    out  serial bit to the converter
//   mod_type_out  out  modulation of the symbol stream
//   sym_start     out  first slot of every symbol
//   frame_active  out  high in every frame slot
//   frame_done    out  pulse in the last frame slot
// All outputs are registered.
// -----------------------------------------------------------------------------
module mod_frame_scheduler #(
    parameter int LEN_W      = 8,
    parameter int GUARD_SYMS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [1:0]       req_mod_type,
    input  logic [LEN_W-1:0] req_len0,
    input  logic [LEN_W-1:0] req_len1,
    input  logic [1:0]       src_bit,
    output logic [1:0]       gnt,
    output logic [1:0]       src_rd,
    output logic             serial_out,
    output logic             mod_type_out,
    output logic             sym_start,
    output logic             frame_active,
    output logic             frame_done
);

    // Symbol counter must hold both the frame symbol index and the guard index.
    localparam int CNT_W = (LEN_W > 4) ? LEN_W : 4;

    typedef enum logic [1:0] {
        ST_PAD   = 2'd0,
        ST_FRAME = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

    state_t           state_r, state_s;
    logic [1:0]       bit_left_r, bit_left_s;   // slots remaining after this one
    logic [CNT_W-1:0] sym_cnt_r, sym_cnt_s;
    logic [LEN_W-1:0] len_r, len_s;
    logic             owner_r, owner_s;
    logic             prio_r, prio_s;
    logic [1:0]       gnt_r, gnt_s;
    logic [1:0]       src_rd_r, src_rd_s;
    logic             serial_r, serial_s;
    logic             mod_type_r, mod_type_s;
    logic             sym_start_r, sym_start_s;
    logic             frame_active_r, frame_active_s;
    logic             frame_done_r, frame_done_s;

    logic [1:0]       bps_m1_s;
    logic             sym_last_s;
    logic             pre_last_s;
    logic             frame_final_s;
    logic             guard_final_s;
    logic             granted_s;
    logic             decision_s;
    logic             frame_end_s;
    logic             next_frame_s;
    logic             pick_s;

    // Slot classification and round-robin pick for the current slot.
    always_comb begin
        // New symbols take their length from the modulation latched so far;
        // a change at a decision edge only affects the following symbol.
        bps_m1_s      = mod_type_r ? 2'd3 : 2'd1;
        sym_last_s    = (bit_left_r == 2'd0);
        pre_last_s    = (bit_left_r == 2'd1);
        frame_final_s = (sym_cnt_r == CNT_W'(len_r));
        guard_final_s = (sym_cnt_r == CNT_W'(GUARD_SYMS - 1));
        granted_s     = (gnt_r != 2'b00);
        decision_s    = pre_last_s &&
                        ((state_r == ST_PAD) || ((state_r == ST_GUARD) && guard_final_s));
        // Edge that enters the last frame slot.
        frame_end_s   = (state_r == ST_FRAME) && pre_last_s && frame_final_s;
        // The upcoming slot carries a source bit.
        next_frame_s  = (granted_s && sym_last_s) ||
                        ((state_r == ST_FRAME) && !(sym_last_s && frame_final_s));
        if (req == 2'b11) begin
            pick_s = prio_r;
        end else begin
            pick_s = req[1];
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_s        = state_r;
        bit_left_s     = bit_left_r;
        sym_cnt_s      = sym_cnt_r;
        len_s          = len_r;
        owner_s        = owner_r;
        prio_s         = prio_r;
        gnt_s          = 2'b00;
        src_rd_s       = src_rd_r;
        mod_type_s     = mod_type_r;
        sym_start_s    = sym_last_s;
        frame_active_s = next_frame_s;
        frame_done_s   = frame_end_s;
        serial_s       = next_frame_s ? src_bit[owner_r] : 1'b0;

        if (sym_last_s) begin
            bit_left_s = bps_m1_s;
        end else begin
            bit_left_s = bit_left_r - 2'd1;
        end

        case (state_r)
            ST_PAD: begin
                if (sym_last_s && granted_s) begin
                    state_s   = ST_FRAME;
                    sym_cnt_s = {CNT_W{1'b0}};
                end else begin
                    state_s   = ST_PAD;
                end
            end
            ST_FRAME: begin
                if (sym_last_s && frame_final_s) begin
                    state_s   = ST_GUARD;
                    sym_cnt_s = {CNT_W{1'b0}};
                end else if (sym_last_s) begin
                    sym_cnt_s = sym_cnt_r + CNT_W'(1);
                end else begin
                    sym_cnt_s = sym_cnt_r;
                end
            end
            ST_GUARD: begin
                if (sym_last_s && granted_s) begin
                    state_s   = ST_FRAME;
                    sym_cnt_s = {CNT_W{1'b0}};
                end else if (sym_last_s && guard_final_s) begin
                    state_s   = ST_PAD;
                    sym_cnt_s = {CNT_W{1'b0}};
                end else if (sym_last_s) begin
                    sym_cnt_s = sym_cnt_r + CNT_W'(1);
                end else begin
                    sym_cnt_s = sym_cnt_r;
                end
            end
            default: begin
                state_s   = ST_PAD;
                sym_cnt_s = {CNT_W{1'b0}};
            end
        endcase

        if (decision_s && (req != 2'b00)) begin
            gnt_s      = onehot2(pick_s);
            src_rd_s   = onehot2(pick_s);
            owner_s    = pick_s;
            prio_s     = ~pick_s;
            mod_type_s = req_mod_type[pick_s];
            len_s      = pick_s ? req_len1 : req_len0;
        end else if (frame_end_s) begin
            // The bit for the last frame slot was pulled in the slot before it.
            src_rd_s   = 2'b00;
        end else begin
            src_rd_s   = src_rd_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_PAD;
            bit_left_r     <= 2'd0;
            sym_cnt_r      <= {CNT_W{1'b0}};
            len_r          <= {LEN_W{1'b0}};
            owner_r        <= 1'b0;
            prio_r         <= 1'b0;
            gnt_r          <= 2'b00;
            src_rd_r       <= 2'b00;
            serial_r       <= 1'b0;
            mod_type_r     <= 1'b0;
            sym_start_r    <= 1'b0;
            frame_active_r <= 1'b0;
            frame_done_r   <= 1'b0;
        end else begin
            state_r        <= state_s;
            bit_left_r     <= bit_left_s;
            sym_cnt_r      <= sym_cnt_s;
            len_r          <= len_s;
            owner_r        <= owner_s;
            prio_r         <= prio_s;
            gnt_r          <= gnt_s;
            src_rd_r       <= src_rd_s;
            serial_r       <= serial_s;
            mod_type_r     <= mod_type_s;
            sym_start_r    <= sym_start_s;
            frame_active_r <= frame_active_s;
            frame_done_r   <= frame_done_s;
        end
    end

    assign gnt          = gnt_r;
    assign src_rd       = src_rd_r;
    assign serial_out   = serial_r;
    assign mod_type_out = mod_type_r;
    assign sym_start    = sym_start_r;
    assign frame_active = frame_active_r;
    assign frame_done   = frame_done_r;

endmodule

// File: doc/mod_frame_scheduler.md
MOD_FRAME_SCHEDULER -- requirements
Module: mod_frame_scheduler

Interface
REQ-001 Parameter LEN_W, default 8: width of the per-requester frame-length field.
REQ-002 Parameter GUARD_SYMS, default 1, legal range 1..15: number of pad symbols inserted after every frame.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req  input  2  per-requester frame request, level.
REQ-006 req_mod_type  input  2  per-requester modulation: bit i for requester i; 0 = QPSK, 1 = 16QAM.
REQ-007 req_len0 / req_len1  input  LEN_W each  frame length in symbols minus one.
REQ-008 src_bit  input  2  per-requester data bit, sampled at the edge that ends a cycle with src_rd[i]=1.
REQ-009 gnt  output  2  one-hot one-cycle grant pulse.
REQ-010 src_rd  output  2  per-requester bit-pull strobe.
REQ-011 serial_out  output  1  registered serial bit to the serial-to-parallel converter.
REQ-012 mod_type_out  output  1  registered modulation type to the converter.
REQ-013 sym_start  output  1  high during the first bit slot of every symbol: frame, guard or pad.
REQ-014 frame_active  output  1  high during every frame bit slot.
REQ-015 frame_done  output  1  one-cycle pulse during the last bit slot of a frame.

Function
REQ-016 Each cycle is one bit slot; a symbol is 2 slots for QPSK and 4 slots for 16QAM, with length set by the current mod_type_out.
REQ-017 FSM states: PAD (idle symbols, serial_out=0), FRAME (source bits), GUARD (GUARD_SYMS symbols, serial_out=0); outputs never emit a partial symbol.
REQ-018 Decision edge is the edge that starts the last bit slot of any PAD symbol or of the final GUARD symbol; arbitration uses req sampled at that edge.
REQ-019 Arbitration is round-robin over 2 requesters: priority goes to the requester not granted last; after reset requester 0 has priority.
REQ-020 At a decision edge with any req set: gnt[g]=1 for that last slot only; mod_type_out, length and g are latched; the next slot is frame bit 0 and the state becomes FRAME.
REQ-021 At a decision edge with no req set, the state stays in PAD; mod_type_out holds its last value.
REQ-022 src_rd[g] is high from the gnt slot through the second-to-last frame slot: exactly (len+1)*bits_per_symbol strobes; src_rd for the non-granted requester stays 0.
REQ-023 serial_out in frame slot k equals src_bit[g] sampled at the end of slot k-1, giving one cycle of latency.
REQ-024 Frame bit order: the first sampled bit is the first bit of symbol 0; symbols are sent consecutively with no gaps.
REQ-025 mod_type_out changes only at a decision edge, so it is stable for the whole frame and for the final slot of the preceding symbol.
REQ-026 Last frame slot: frame_done=1, frame_active=1; next slot is GUARD symbol 0; frame_active=0 in every GUARD and PAD slot.
REQ-027 After the final GUARD symbol with no decision made, the state returns to PAD.
REQ-028 Changes to req, req_len or req_mod_type after the decision edge have no effect on the frame in progress; deasserting req mid-frame does not truncate the frame.
REQ-029 A requester still holding req after its frame is eligible again; with both requesting, grants alternate 0,1,0,1.
REQ-030 Length wrap: a req_len of all-ones sends 2^LEN_W symbols; the symbol counter does not overflow early.

Reset
REQ-031 While rst=1: gnt=0, src_rd=0, serial_out=0, mod_type_out=0, sym_start=0, frame_active=0, frame_done=0, state=PAD, bit/symbol counters=0, priority=requester 0.
REQ-032 The first slot after rst deasserts is bit 0 of a QPSK PAD symbol (sym_start=1).
REQ-033 Reset mid-frame aborts immediately: no frame_done pulse and no further src_rd; the aborted requester loses no priority.

Verification
REQ-034 Idle after reset, no req -> serial_out=0; sym_start pulses every 2 cycles; gnt never asserts.
REQ-035 req[0]=1, QPSK, len0=3 -> gnt[0] in a PAD last slot; 8 src_rd[0] pulses; 8 frame_active slots; bits match source order; frame_done on slot 8; then 1 GUARD symbol.
REQ-036 req[1]=1, 16QAM, len1=1, following a QPSK frame -> mod_type_out rises in the gnt slot; 8 frame slots with sym_start on slots 1 and 5.
REQ-037 Both req held, lengths 0, mixed types -> grants 0,1,0,1; each grant is separated from the previous frame_done by exactly GUARD_SYMS symbols.
REQ-038 rst pulsed during symbol 2 of a 16QAM frame -> all outputs 0 immediately; no frame_done; after release, a QPSK PAD symbol, then requester 0 is granted if both request.
REQ-039 len0=8'hFF, QPSK -> exactly 512 frame slots, then frame_done.
